// File: rtl/psu_seq_pkg.sv
// rtl/psu_seq_pkg.sv - shared widths, opcodes, select codes, state encodings for psu_seq
// Contents: bus widths, opcode values, SELCNT_* codes, S_* state encodings,
//           step_t (cascaded step flags) and sel_decode (opcode -> select).
package psu_seq_pkg;

  localparam int OPCODE_BW = 4;
  localparam int IDLEN_BW  = 4;
  localparam int QBADDR_BW = 4;
  localparam int UCADDR_BW = 4;
  localparam int ROUND_BW  = 4;

  localparam logic [OPCODE_BW-1:0] OP_LQI        = 4'd1;
  localparam logic [OPCODE_BW-1:0] OP_INIT_INTMD = 4'd2;
  localparam logic [OPCODE_BW-1:0] OP_LQM_X      = 4'd3;
  localparam logic [OPCODE_BW-1:0] OP_LQM_Y      = 4'd4;
  localparam logic [OPCODE_BW-1:0] OP_LQM_Z      = 4'd5;
  localparam logic [OPCODE_BW-1:0] OP_MEAS_INTMD = 4'd6;
  localparam logic [OPCODE_BW-1:0] OP_RUN_ESM    = 4'd7;

  localparam logic [1:0] SELCNT_INVALID = 2'd0;
  localparam logic [1:0] SELCNT_INIT    = 2'd1;
  localparam logic [1:0] SELCNT_MEAS    = 2'd2;
  localparam logic [1:0] SELCNT_RESM    = 2'd3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READY   = 2'd1;
  localparam logic [1:0] S_RUNNING = 2'd2;

  // Carry chain of one work beat: each flag implies the one before it.
  typedef struct packed {
    logic next_uc;
    logic next_pch;
    logic next_id;
    logic next_round;
    logic next_opcode;
  } step_t;

  function automatic logic [1:0] sel_decode(input logic [OPCODE_BW-1:0] op);
    logic [1:0] sel;
    case (op)
      OP_LQI, OP_INIT_INTMD:                       sel = SELCNT_INIT;
      OP_LQM_X, OP_LQM_Y, OP_LQM_Z, OP_MEAS_INTMD: sel = SELCNT_MEAS;
      OP_RUN_ESM:                                  sel = SELCNT_RESM;
      default:                                     sel = SELCNT_INVALID;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/psu_seq_if.sv
// rtl/psu_seq_if.sv - instruction, patch-info and work-beat signals of psu_seq
// master: drives inst_*, pchinfo_valid/rdlast/nextready, stall; observes the rest.
// slave : the sequencer; drives inst_ready, pchinfo_rd, psu_valid, counters,
//         opcode_running, sel_cwdNtime, op_done, busy.
interface psu_seq_if;
  import psu_seq_pkg::*;

  logic                 inst_valid;
  logic [OPCODE_BW-1:0] inst_opcode;
  logic [IDLEN_BW-1:0]  inst_id_len;
  logic                 inst_ready;
  logic                 pchinfo_valid;
  logic                 pchinfo_rdlast;
  logic                 pchinfo_nextready;
  logic                 pchinfo_rd;
  logic                 stall;
  logic                 psu_valid;
  logic [OPCODE_BW-1:0] opcode_running;
  logic [1:0]           sel_cwdNtime;
  logic [QBADDR_BW-1:0] qb_counter0;
  logic [UCADDR_BW-1:0] uc_counter0;
  logic [IDLEN_BW-1:0]  id_counter;
  logic [ROUND_BW-1:0]  round_counter;
  logic                 op_done;
  logic                 busy;

  modport master (
    output inst_valid, inst_opcode, inst_id_len,
    output pchinfo_valid, pchinfo_rdlast, pchinfo_nextready, stall,
    input  inst_ready, pchinfo_rd, psu_valid, opcode_running, sel_cwdNtime,
    input  qb_counter0, uc_counter0, id_counter, round_counter, op_done, busy
  );

  modport slave (
    input  inst_valid, inst_opcode, inst_id_len,
    input  pchinfo_valid, pchinfo_rdlast, pchinfo_nextready, stall,
    output inst_ready, pchinfo_rd, psu_valid, opcode_running, sel_cwdNtime,
    output qb_counter0, uc_counter0, id_counter, round_counter, op_done, busy
  );

endinterface

// File: rtl/psu_ctrl.sv
// rtl/psu_ctrl.sv - combinational step cascade and select decode for the patch scan unit
// Inputs : qb, uc, id, id_len, round counters, opcode, pchinfo_rdlast.
// Outputs: step (next_* flags), next counter values, sel (decoded from opcode).
module psu_ctrl
  import psu_seq_pkg::*;
#(
  parameter int NUM_QB     = 4,
  parameter int NUM_QBCTRL = 2,
  parameter int NUM_UC     = 2,
  parameter int NUM_UCC    = 1,
  parameter int CODE_DIST  = 3
) (
  input  logic [QBADDR_BW-1:0] qb,
  input  logic [UCADDR_BW-1:0] uc,
  input  logic [IDLEN_BW-1:0]  id,
  input  logic [IDLEN_BW-1:0]  id_len,
  input  logic [ROUND_BW-1:0]  round,
  input  logic [OPCODE_BW-1:0] opcode,
  input  logic                 pchinfo_rdlast,
  output step_t                step,
  output logic [QBADDR_BW-1:0] qb_nxt,
  output logic [UCADDR_BW-1:0] uc_nxt,
  output logic [IDLEN_BW-1:0]  id_nxt,
  output logic [ROUND_BW-1:0]  round_nxt,
  output logic [1:0]           sel
);

  // One spare bit so qb/uc plus the beat width never wraps before the compare;
  // this is what lets a partial last beat (NUM_QB % NUM_QBCTRL != 0) still wrap.
  logic [QBADDR_BW:0] qb_sum;
  logic [UCADDR_BW:0] uc_sum;

  assign qb_sum = {1'b0, qb} + (QBADDR_BW+1)'(NUM_QBCTRL);
  assign uc_sum = {1'b0, uc} + (UCADDR_BW+1)'(NUM_UCC);

  always_comb begin
    step             = '0;
    step.next_uc     = qb_sum >= (QBADDR_BW+1)'(NUM_QB);
    step.next_pch    = step.next_uc & (uc_sum >= (UCADDR_BW+1)'(NUM_UC));
    step.next_id     = step.next_pch & pchinfo_rdlast;
    step.next_round  = step.next_id & (id == id_len - 1'b1);
    step.next_opcode = step.next_round &
                       ((opcode != OP_RUN_ESM) | (round == ROUND_BW'(CODE_DIST - 1)));

    qb_nxt    = step.next_uc ? '0 : qb_sum[QBADDR_BW-1:0];
    uc_nxt    = step.next_pch ? '0 : (step.next_uc ? uc_sum[UCADDR_BW-1:0] : uc);
    id_nxt    = step.next_round ? '0 : (step.next_id ? id + 1'b1 : id);
    round_nxt = step.next_opcode ? '0 : (step.next_round ? round + 1'b1 : round);
    sel       = sel_decode(opcode);
  end

endmodule

// File: rtl/psu_seq.sv
// rtl/psu_seq.sv - patch scan unit sequencer: opcode fetch, state machine, counters
// Ports: clk, rst_n (async, active low), bus (psu_seq_if.slave):
//        inst_* opcode handshake, pchinfo_* patch-info handshake, stall,
//        psu_valid work beat, counters, opcode_running, sel_cwdNtime, op_done, busy.
module psu_seq
  import psu_seq_pkg::*;
#(
  parameter int NUM_QB     = 4,
  parameter int NUM_QBCTRL = 2,
  parameter int NUM_UC     = 2,
  parameter int NUM_UCC    = 1,
  parameter int CODE_DIST  = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  psu_seq_if.slave bus
);

  logic [1:0]           state;
  logic [OPCODE_BW-1:0] opcode_r;
  logic [IDLEN_BW-1:0]  id_len_r;
  logic [QBADDR_BW-1:0] qb;
  logic [UCADDR_BW-1:0] uc;
  logic [IDLEN_BW-1:0]  id;
  logic [ROUND_BW-1:0]  round;
  logic                 op_done_r;

  step_t                step;
  logic [QBADDR_BW-1:0] qb_nxt;
  logic [UCADDR_BW-1:0] uc_nxt;
  logic [IDLEN_BW-1:0]  id_nxt;
  logic [ROUND_BW-1:0]  round_nxt;
  logic [1:0]           sel;

  logic inst_ready;
  logic accept;
  logic en;
  logic fetch_invalid;

  psu_ctrl #(
    .NUM_QB     (NUM_QB),
    .NUM_QBCTRL (NUM_QBCTRL),
    .NUM_UC     (NUM_UC),
    .NUM_UCC    (NUM_UCC),
    .CODE_DIST  (CODE_DIST)
  ) u_ctrl (
    .qb             (qb),
    .uc             (uc),
    .id             (id),
    .id_len         (id_len_r),
    .round          (round),
    .opcode         (opcode_r),
    .pchinfo_rdlast (bus.pchinfo_rdlast),
    .step           (step),
    .qb_nxt         (qb_nxt),
    .uc_nxt         (uc_nxt),
    .id_nxt         (id_nxt),
    .round_nxt      (round_nxt),
    .sel            (sel)
  );

  // Holding ready low during op_done keeps one dead cycle between opcodes.
  assign inst_ready    = (state == S_IDLE) & ~op_done_r;
  assign accept        = inst_ready & bus.inst_valid;
  assign en            = (state == S_RUNNING) & ~bus.stall;
  assign fetch_invalid = sel_decode(bus.inst_opcode) == SELCNT_INVALID;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opcode_r  <= '0;
      id_len_r  <= '0;
      qb        <= '0;
      uc        <= '0;
      id        <= '0;
      round     <= '0;
      op_done_r <= 1'b0;
    end else begin
      op_done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            opcode_r <= bus.inst_opcode;
            id_len_r <= (bus.inst_id_len == '0) ? IDLEN_BW'(1) : bus.inst_id_len;
            if (fetch_invalid) op_done_r <= 1'b1;
            else               state     <= S_READY;
          end
        end
        S_READY: begin
          if (bus.pchinfo_valid) state <= S_RUNNING;
        end
        S_RUNNING: begin
          if (en) begin
            // On next_opcode every *_nxt value is already zero.
            qb    <= qb_nxt;
            uc    <= uc_nxt;
            id    <= id_nxt;
            round <= round_nxt;
            if (step.next_opcode) begin
              state     <= S_IDLE;
              op_done_r <= 1'b1;
            end else if (step.next_id & ~bus.pchinfo_nextready) begin
              state <= S_READY;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.inst_ready     = inst_ready;
  assign bus.psu_valid      = en;
  assign bus.pchinfo_rd     = en & step.next_pch;
  assign bus.opcode_running = opcode_r;
  assign bus.sel_cwdNtime   = (state == S_IDLE) ? SELCNT_INVALID : sel;
  assign bus.qb_counter0    = qb;
  assign bus.uc_counter0    = uc;
  assign bus.id_counter     = id;
  assign bus.round_counter  = round;
  assign bus.op_done        = op_done_r;
  assign bus.busy           = state != S_IDLE;

endmodule
